// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: tx_state_t FSM encoding, calc_ticks_per_bit() baud divider.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } tx_state_t;

  // Clock cycles per serial bit; integer division, remainder dropped.
  function automatic int calc_ticks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Word-producer handshake into the UART transmit buffer.
// Latency: n/a (wires only). Backpressure: ready low means the word is not taken.
// Ports: data/valid from the producer, ready back from the buffer.
interface uart_tx_buf_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO holding words waiting for the serialiser.
// Latency: a pushed word is visible at data_o the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge.
// Ports: clock/resetn, push_i/data_i in, pop_i/data_o out, full_o/empty_o/level_o status.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a full FIFO can still take a word.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];
  assign level_o = level_q;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only read while level_q says they are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO of words serialised as start/data(LSB first)/[parity]/stop.
// Latency: head word popped one edge after it is queued; line falls on the next cycle.
// Backpressure: ready = FIFO not full; valid while !ready is ignored.
// Ports: clock, resetn (async, active low), bus (data/valid/ready), signal (TX line,
// idle high), busy (frame running or words queued), level (FIFO occupancy).
// Optional feature macro: UART_TX_PARITY_EN inserts one parity bit per frame.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 460800,
  parameter int DEPTH      = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clock,
  input  logic                   resetn,
  uart_tx_buf_if.slave           bus,
  output logic                   signal,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int TICKS = calc_ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CW    = $clog2(TICKS);
  localparam int BW    = $clog2(WIDTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (TICKS < 2) begin : g_chk_rate
    $error("uart_tx_buf: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if (WIDTH < 5 || WIDTH > 9) begin : g_chk_width
    $error("uart_tx_buf: WIDTH must be 5..9");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_buf: DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_buf: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
    $error("uart_tx_buf: PARITY_ODD must be 0 or 1");
  end

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  assign bus.ready = !fifo_full;
  assign fifo_push = bus.valid && bus.ready;

  uart_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (fifo_push),
    .data_i  (bus.data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  tx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;     // data bit index, reused as stop-bit index
  logic [WIDTH-1:0] shift_q, shift_d; // private copy of the word, so later pushes cannot touch it
  logic             tx_q, tx_d;
  logic             tick;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_q, par_d;
`endif

  assign tick = (cnt_q == TICK_LAST);

  // State register; the line is registered so reset drives it high without a comb glitch.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    // Baud counter idles at zero, so every bit starts with a full period.
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (!fifo_empty) begin
              state_d  = START;
              fifo_pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
      par_d   = (^fifo_head) ^ PAR_SENSE;
`endif
    end
  end

  // Output logic: line level for the state being entered, plus busy status.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != IDLE) || !fifo_empty;
  end

  assign signal = tx_q;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: three instances (A: 1 stop even, B: 2 stop odd,
// C: 1 stop odd), 48 clocks per bit; frames are decoded off the line and compared
// with hand-computed words, lengths and parity bits.
module tb_uart_tx_buf;
  localparam int TPB = 48;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  uart_tx_buf_if #(.WIDTH(8)) ifa ();
  uart_tx_buf_if #(.WIDTH(8)) ifb ();
  uart_tx_buf_if #(.WIDTH(8)) ifc ();

  logic       sig_a, sig_b, sig_c, busy_a, busy_b, busy_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;

  uart_tx_buf #(.WIDTH(8), .BAUD_RATE(9600), .CLOCK_FREQ(460800), .DEPTH(4),
                .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clock(clock), .resetn(resetn), .bus(ifa.slave),
    .signal(sig_a), .busy(busy_a), .level(lvl_a));
  uart_tx_buf #(.WIDTH(8), .BAUD_RATE(9600), .CLOCK_FREQ(460800), .DEPTH(4),
                .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clock(clock), .resetn(resetn), .bus(ifb.slave),
    .signal(sig_b), .busy(busy_b), .level(lvl_b));
  uart_tx_buf #(.WIDTH(8), .BAUD_RATE(9600), .CLOCK_FREQ(460800), .DEPTH(4),
                .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
    .clock(clock), .resetn(resetn), .bus(ifc.slave),
    .signal(sig_c), .busy(busy_c), .level(lvl_c));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rx(input int sel);
    case (sel)
      0:       return sig_a;
      1:       return sig_b;
      default: return sig_c;
    endcase
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ifa.ready;
      1:       return ifb.ready;
      default: return ifc.ready;
    endcase
  endfunction

  // Called on a negedge; offers one word for one clock edge, returns on the next negedge.
  task automatic push(input int sel, input logic [7:0] d, input string tag);
    case (sel)
      0:       begin ifa.data = d; ifa.valid = 1'b1; end
      1:       begin ifb.data = d; ifb.valid = 1'b1; end
      default: begin ifc.data = d; ifc.valid = 1'b1; end
    endcase
    check(tag, rdy(sel), 1);
    @(negedge clock);
    ifa.valid = 1'b0;
    ifb.valid = 1'b0;
    ifc.valid = 1'b0;
  endtask

  // One bit period starting at the current negedge; counts samples that differ from the first.
  task automatic sample_bit(input int sel, output logic v, inout int bad, inout int cyc,
                            output int ones);
    v    = rx(sel);
    ones = int'(v);
    cyc++;
    for (int k = 1; k < TPB; k++) begin
      @(negedge clock);
      if (rx(sel) !== v) bad++;
      ones += int'(rx(sel));
      cyc++;
    end
  endtask

  // Waits (bounded) for a start bit, then decodes a whole frame; ends on its last sample.
  task automatic capture(input int sel, input int nstop, output logic [7:0] word,
                         output logic par, output int gap, output int bad,
                         output int cyc, output int stop_hi);
    logic v;
    int   ones;
    gap = 0; bad = 0; cyc = 0; stop_hi = 0; word = '0; par = 1'b0;
    @(negedge clock);
    while (rx(sel) !== 1'b0 && gap < 2000) begin
      gap++;
      @(negedge clock);
    end
    if (gap >= 2000) begin
      check("start_timeout", gap, 0);
      bad = 1;
      return;
    end
    sample_bit(sel, v, bad, cyc, ones);
    if (v !== 1'b0) bad++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      sample_bit(sel, v, bad, cyc, ones);
      word[i] = v;
    end
`ifdef UART_TX_PARITY_EN
    @(negedge clock);
    sample_bit(sel, v, bad, cyc, ones);
    par = v;
`endif
    for (int s = 0; s < nstop; s++) begin
      @(negedge clock);
      sample_bit(sel, v, bad, cyc, ones);
      stop_hi += ones;
    end
  endtask

  logic [7:0] burst [5] = '{8'h11, 8'h3C, 8'h80, 8'h01, 8'hE7};
  logic [7:0] rst_w [4] = '{8'h81, 8'h42, 8'h24, 8'h18};
  logic [7:0] got_w   [5];
  logic       got_par [5];
  int         got_gap [5], got_bad [5], got_cyc [5], got_stop [5];

  logic mon_en = 1'b0;
  int   viol4  = 0;
  int   ovf    = 0;
  always @(negedge clock) begin
    if (mon_en) begin
      if (lvl_a == 3'd4 && ifa.ready) viol4++;
      if (lvl_a > 3'd4) ovf++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lows, busys, lvls;
    ifa.valid = 1'b0; ifa.data = '0;
    ifb.valid = 1'b0; ifb.data = '0;
    ifc.valid = 1'b0; ifc.data = '0;

    // Reset values.
    repeat (2) @(negedge clock);
    check("rst_signal", sig_a, 1);
    check("rst_ready", ifa.ready, 1);
    check("rst_busy", busy_a, 0);
    check("rst_level", lvl_a, 0);
    check("rst_signal_b", sig_b, 1);
    resetn = 1'b1;

    // 100 quiet cycles.
    n = 0;
    repeat (100) begin
      @(negedge clock);
      if (sig_a !== 1'b1 || ifa.ready !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0) n++;
    end
    check("idle_100", n, 0);

    // Single 0xA5 frame.
    push(0, 8'hA5, "a5_push_ready");
    capture(0, 1, got_w[0], got_par[0], got_gap[0], got_bad[0], got_cyc[0], got_stop[0]);
    check("a5_word", got_w[0], 8'hA5);
    check("a5_stable", got_bad[0], 0);
    check("a5_len", got_cyc[0], (10 + P) * TPB);
`ifdef UART_TX_PARITY_EN
    check("a5_par", got_par[0], 0);
`endif
    check("a5_busy_in_stop", busy_a, 1);
    @(negedge clock);
    check("a5_busy_drop", busy_a, 0);
    check("a5_idle_high", sig_a, 1);

    // 0x07 with even (A) and odd (C) parity sense.
    push(0, 8'h07, "e07_push_ready");
    capture(0, 1, got_w[0], got_par[0], got_gap[0], got_bad[0], got_cyc[0], got_stop[0]);
    check("e07_word", got_w[0], 8'h07);
    check("e07_len", got_cyc[0], (10 + P) * TPB);
`ifdef UART_TX_PARITY_EN
    check("e07_par", got_par[0], 1);
`endif
    @(negedge clock);
    push(2, 8'h07, "o07_push_ready");
    capture(2, 1, got_w[0], got_par[0], got_gap[0], got_bad[0], got_cyc[0], got_stop[0]);
    check("o07_word", got_w[0], 8'h07);
    check("o07_len", got_cyc[0], (10 + P) * TPB);
`ifdef UART_TX_PARITY_EN
    check("o07_par", got_par[0], 0);
`endif
    @(negedge clock);

    // Five words offered on consecutive cycles, decoded as they go out.
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) push(0, burst[i], "burst_push_ready");
        check("burst_level4", lvl_a, 4);
        check("burst_ready_low", ifa.ready, 0);
      end
      begin
        for (int i = 0; i < 5; i++)
          capture(0, 1, got_w[i], got_par[i], got_gap[i], got_bad[i], got_cyc[i], got_stop[i]);
      end
    join
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_word%0d", i), got_w[i], burst[i]);
      check($sformatf("burst_stable%0d", i), got_bad[i], 0);
      if (i > 0) check($sformatf("burst_gap%0d", i), got_gap[i], 0);
    end
    check("burst_ready_at_full", viol4, 0);
    check("burst_overflow", ovf, 0);
    @(negedge clock);
    check("burst_busy_drop", busy_a, 0);

    // Reset 200 cycles into a frame with three words still queued.
    fork
      for (int i = 0; i < 4; i++) push(0, rst_w[i], "rst_push_ready");
      begin
        n = 0;
        @(negedge clock);
        while (sig_a !== 1'b0 && n < 100) begin
          n++;
          @(negedge clock);
        end
        check("rst_frame_started", (n < 100), 1);
        repeat (200) @(negedge clock);
      end
    join
    check("rst_pre_level", lvl_a, 3);
    check("rst_pre_line_low", sig_a, 0);
    resetn = 1'b0;
    #1;
    check("rst_mid_signal", sig_a, 1);
    check("rst_mid_level", lvl_a, 0);
    check("rst_mid_ready", ifa.ready, 1);
    check("rst_mid_busy", busy_a, 0);
    @(negedge clock);
    resetn = 1'b1;
    lows = 0; busys = 0; lvls = 0;
    repeat (600) begin
      @(negedge clock);
      if (sig_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busys++;
      if (lvl_a !== 3'd0) lvls++;
    end
    check("post_rst_line_low", lows, 0);
    check("post_rst_busy", busys, 0);
    check("post_rst_level", lvls, 0);

    // Two stop bits: 0xFF then 0x00 back to back on B.
    fork
      begin
        push(1, 8'hFF, "s2_push_ready");
        push(1, 8'h00, "s2_push_ready");
      end
      begin
        capture(1, 2, got_w[0], got_par[0], got_gap[0], got_bad[0], got_cyc[0], got_stop[0]);
        capture(1, 2, got_w[1], got_par[1], got_gap[1], got_bad[1], got_cyc[1], got_stop[1]);
      end
    join
    check("s2_word0", got_w[0], 8'hFF);
    check("s2_word1", got_w[1], 8'h00);
    check("s2_stop_high", got_stop[0], 2 * TPB);
    check("s2_gap", got_gap[1], 0);
    check("s2_len", got_cyc[0], (11 + P) * TPB);
    check("s2_stable", got_bad[0] + got_bad[1], 0);
`ifdef UART_TX_PARITY_EN
    check("s2_par0", got_par[0], 1);
    check("s2_par1", got_par[1], 1);
`endif
    @(negedge clock);
    check("s2_busy_drop", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
